// File: rtl/score_controller.sv
// Pong score keeper with a shared iterative divide-by-10 digit converter.
// Round-robin arbitration picks which dirty score is converted next.
module score_controller #(
    parameter int WIN_SCORE = 11
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       new_game,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [6:0] score1,
    output logic [6:0] score2,
    output logic [3:0] tens_1,
    output logic [3:0] ones_1,
    output logic [3:0] tens_2,
    output logic [3:0] ones_2,
    output logic       digits_valid,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    localparam logic [6:0] WIN7 = 7'(WIN_SCORE);

    state_t     state;
    state_t     state_nxt;
    logic       dirty1;
    logic       dirty2;
    logic       last_served;
    logic       sel;
    logic [6:0] work;
    logic [3:0] tens_acc;

    logic       inc1;
    logic       inc2;
    logic [6:0] score1_inc;
    logic [6:0] score2_inc;
    logic       win1;
    logic       win2;
    logic       pick;
    logic       start;
    logic       done;
    logic       clr1;
    logic       clr2;

    assign inc1       = point_p1 & ~game_over & ~new_game;
    assign inc2       = point_p2 & ~game_over & ~new_game;
    assign score1_inc = score1 + 7'd1;
    assign score2_inc = score2 + 7'd1;
    assign win1       = inc1 & (score1_inc == WIN7);
    assign win2       = inc2 & (score2_inc == WIN7);

    assign start = (state == IDLE) & (dirty1 | dirty2) & ~new_game;
    assign done  = (state == DIV) & (work < 7'd10);
    assign clr1  = start & ~pick;
    assign clr2  = start & pick;

    assign digits_valid = (state == IDLE) & ~dirty1 & ~dirty2;

    // Arbiter: a lone dirty score wins; a tie goes to the player not served last.
    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            dirty1 & dirty2:  pick = ~last_served;
            ~dirty1 & dirty2: pick = 1'b1;
            default:          pick = 1'b0;
        endcase
    end

    // Converter state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Converter next state; new_game aborts any conversion in flight.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = DIV;
            DIV:  if (done)  state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
        if (new_game) state_nxt = IDLE;
    end

    // Scores, win detection, dirty flags and the divider datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score1      <= '0;
            score2      <= '0;
            tens_1      <= '0;
            ones_1      <= '0;
            tens_2      <= '0;
            ones_2      <= '0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            dirty1      <= 1'b0;
            dirty2      <= 1'b0;
            last_served <= 1'b1;
            sel         <= 1'b0;
            work        <= '0;
            tens_acc    <= '0;
        end else if (new_game) begin
            score1    <= '0;
            score2    <= '0;
            tens_1    <= '0;
            ones_1    <= '0;
            tens_2    <= '0;
            ones_2    <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            dirty1    <= 1'b0;
            dirty2    <= 1'b0;
        end else begin
            if (inc1) score1 <= score1_inc;
            if (inc2) score2 <= score2_inc;
            if (win1 | win2) begin
                game_over <= 1'b1;
                winner    <= ~win1;
            end
            // A fresh point outranks the clear issued on the capture edge.
            dirty1 <= (dirty1 & ~clr1) | inc1;
            dirty2 <= (dirty2 & ~clr2) | inc2;
            if (start) begin
                sel         <= pick;
                work        <= pick ? score2 : score1;
                tens_acc    <= '0;
                last_served <= pick;
            end else if (state == DIV) begin
                if (!done) begin
                    work     <= work - 7'd10;
                    tens_acc <= tens_acc + 4'd1;
                end else if (sel) begin
                    tens_2 <= tens_acc;
                    ones_2 <= work[3:0];
                end else begin
                    tens_1 <= tens_acc;
                    ones_1 <= work[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: vector table plus timing sequences.
// Instance a uses WIN_SCORE=11, instance b WIN_SCORE=99; both share stimulus.
module tb_score_controller;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic new_game = 1'b0;
    logic point_p1 = 1'b0;
    logic point_p2 = 1'b0;

    logic [6:0] a_s1, a_s2, b_s1, b_s2;
    logic [3:0] a_t1, a_o1, a_t2, a_o2;
    logic [3:0] b_t1, b_o1, b_t2, b_o2;
    logic       a_v, a_go, a_w, b_v, b_go, b_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_controller #(.WIN_SCORE(11)) dut_a (
        .clk(clk), .resetn(resetn), .new_game(new_game),
        .point_p1(point_p1), .point_p2(point_p2),
        .score1(a_s1), .score2(a_s2),
        .tens_1(a_t1), .ones_1(a_o1), .tens_2(a_t2), .ones_2(a_o2),
        .digits_valid(a_v), .game_over(a_go), .winner(a_w)
    );

    score_controller #(.WIN_SCORE(99)) dut_b (
        .clk(clk), .resetn(resetn), .new_game(new_game),
        .point_p1(point_p1), .point_p2(point_p2),
        .score1(b_s1), .score2(b_s2),
        .tens_1(b_t1), .ones_1(b_o1), .tens_2(b_t2), .ones_2(b_o2),
        .digits_valid(b_v), .game_over(b_go), .winner(b_w)
    );

    function automatic logic [32:0] pk(
        input logic [6:0] s1, input logic [6:0] s2,
        input logic [3:0] t1, input logic [3:0] o1,
        input logic [3:0] t2, input logic [3:0] o2,
        input logic go, input logic w, input logic v);
        return {s1, s2, t1, o1, t2, o2, go, w, v};
    endfunction

    logic [32:0] obs_a, obs_b;
    assign obs_a = pk(a_s1, a_s2, a_t1, a_o1, a_t2, a_o2, a_go, a_w, a_v);
    assign obs_b = pk(b_s1, b_s2, b_t1, b_o1, b_t2, b_o2, b_go, b_w, b_v);

    typedef struct {
        logic        ng;
        logic        p1;
        logic        p2;
        int          wait_n;
        logic [32:0] exp_a;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ng, input logic p1, input logic p2);
        new_game = ng;
        point_p1 = p1;
        point_p2 = p2;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1,  pk(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 12, pk(1, 0, 0, 1, 0, 0, 0, 0, 1)};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 12, pk(1, 1, 0, 1, 0, 1, 0, 0, 1)};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 12, pk(2, 2, 0, 2, 0, 2, 0, 0, 1)};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 12, pk(3, 3, 0, 3, 0, 3, 0, 0, 1)};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 12, pk(3, 4, 0, 3, 0, 4, 0, 0, 1)};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 0,  pk(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 12, pk(1, 1, 0, 1, 0, 1, 0, 0, 1)};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 12, pk(2, 2, 0, 2, 0, 2, 0, 0, 1)};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 12, pk(3, 3, 0, 3, 0, 3, 0, 0, 1)};

        // Reset state
        tick(3);
        chk("reset_a", obs_a, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("reset_b", obs_b, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        resetn = 1'b1;
        tick(1);

        // Single-digit scores commit two edges after the point edge
        for (int k = 1; k <= 5; k++) begin
            pulse(0, 1, 0);
            chk("p1_valid_e0", 33'(a_v), 33'(0));
            tick(1);
            chk("p1_valid_e1", 33'(a_v), 33'(0));
            tick(1);
            chk("p1_commit", obs_a, pk(7'(k), 0, 0, 4'(k), 0, 0, 0, 0, 1));
            tick(18);
        end

        // Score 10 takes one subtract cycle; valid low for 3 samples
        for (int k = 6; k <= 9; k++) begin
            pulse(0, 1, 0);
            tick(12);
        end
        pulse(0, 1, 0);
        chk("ten_valid_e0", 33'(a_v), 33'(0));
        tick(1);
        chk("ten_valid_e1", 33'(a_v), 33'(0));
        tick(1);
        chk("ten_valid_e2", 33'(a_v), 33'(0));
        tick(1);
        chk("ten_commit", obs_a, pk(10, 0, 1, 0, 0, 0, 0, 0, 1));

        // Vector table
        for (int i = 0; i < 10; i++) begin
            pulse(vecs[i].ng, vecs[i].p1, vecs[i].p2);
            tick(vecs[i].wait_n);
            chk($sformatf("vec%0d", i), obs_a, vecs[i].exp_a);
        end

        // Simultaneous points from 3/3: P1 first, P2 after one idle cycle
        pulse(0, 1, 1);
        chk("tie_e0", obs_a, pk(4, 4, 0, 3, 0, 3, 0, 0, 0));
        tick(2);
        chk("tie_p1_commit", obs_a, pk(4, 4, 0, 4, 0, 3, 0, 0, 0));
        tick(1);
        chk("tie_idle_gap", obs_a, pk(4, 4, 0, 4, 0, 3, 0, 0, 0));
        tick(1);
        chk("tie_p2_commit", obs_a, pk(4, 4, 0, 4, 0, 4, 0, 0, 1));
        pulse(0, 1, 1);
        tick(2);
        chk("tie2_p1_first", obs_a, pk(5, 5, 0, 5, 0, 4, 0, 0, 0));
        tick(2);
        chk("tie2_done", obs_a, pk(5, 5, 0, 5, 0, 5, 0, 0, 1));

        // P1 point while P2 is in DIV
        pulse(1, 0, 0);
        for (int k = 0; k < 14; k++) begin
            pulse(0, 0, 1);
            tick(12);
        end
        chk("p2_14", obs_b, pk(0, 14, 0, 0, 1, 4, 0, 0, 1));
        pulse(0, 0, 1);
        tick(1);
        pulse(0, 1, 0);
        chk("mid_div_e2", obs_b, pk(1, 15, 0, 0, 1, 4, 0, 0, 0));
        tick(1);
        chk("mid_div_p2", obs_b, pk(1, 15, 0, 0, 1, 5, 0, 0, 0));
        tick(2);
        chk("mid_div_p1", obs_b, pk(1, 15, 0, 1, 1, 5, 0, 0, 1));

        // Both reach 11 on the same edge: player 1 wins
        pulse(1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            pulse(0, 1, 1);
            tick(12);
        end
        pulse(0, 1, 1);
        chk("win_tie_edge", obs_a, pk(11, 11, 1, 0, 1, 0, 1, 0, 0));
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        tick(20);
        chk("win_tie_final", obs_a, pk(11, 11, 1, 1, 1, 1, 1, 0, 1));

        // Player 2 alone reaches 11: winner is 1
        pulse(1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            pulse(0, 0, 1);
            tick(12);
        end
        pulse(0, 1, 0);
        tick(12);
        pulse(0, 0, 1);
        chk("win_p2_edge", 33'({a_go, a_w}), 33'(2'b11));
        tick(12);
        chk("win_p2_final", obs_a, pk(1, 11, 0, 1, 1, 1, 1, 1, 1));

        // new_game mid-conversion at 57
        pulse(1, 0, 0);
        for (int k = 0; k < 56; k++) begin
            pulse(0, 1, 0);
            tick(12);
        end
        chk("score56", obs_b, pk(56, 0, 5, 6, 0, 0, 0, 0, 1));
        pulse(0, 1, 0);
        tick(3);
        pulse(1, 0, 0);
        chk("ng_mid_b", obs_b, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("ng_mid_a", obs_a, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Worst case 99: commit at E+11, game over on E
        for (int k = 0; k < 98; k++) begin
            pulse(0, 1, 0);
            tick(12);
        end
        pulse(0, 1, 0);
        chk("s99_edge", obs_b, pk(99, 0, 9, 8, 0, 0, 1, 0, 0));
        tick(10);
        chk("s99_e10", 33'(b_v), 33'(0));
        tick(1);
        chk("s99_commit", obs_b, pk(99, 0, 9, 9, 0, 0, 1, 0, 1));

        // Asynchronous reset while DIV is busy
        pulse(1, 0, 0);
        for (int k = 0; k < 30; k++) pulse(0, 1, 0);
        tick(2);
        chk("pre_rst_busy", 33'(b_v), 33'(0));
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_b", obs_b, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("async_rst_a", obs_a, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick(2);
        resetn = 1'b1;
        tick(2);
        chk("post_rst", obs_b, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
